// File: rtl/backprop_pkg.sv
// Shared types and constants for the layer back-propagation sequencer.
// Pure declarations: no latency, no flow control of its own.
package backprop_pkg;
  localparam int DATA_W = 32;
  localparam int BP_W   = 64;

  typedef enum logic [2:0] {IDLE, READ, EXEC, DRAIN, DONE} bps_state_t;

  // Flat weight address of input i of neuron j.
  function automatic int widx(input int j, input int i, input int n_in);
    return j * n_in + i;
  endfunction
endpackage

// File: rtl/bp_err_accum.sv
// Bank of N_IN wrapping 32-bit error sums: clear and indexed add land one cycle
// after they are requested; the indexed read is combinational. No backpressure.
module bp_err_accum import backprop_pkg::*; #(
  parameter int N_IN = 8,
  parameter int IW   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [IW-1:0]     add_idx,
  input  logic [DATA_W-1:0] add_val,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);
  // Bank is padded to a power of two so every index value selects a real entry.
  localparam int DEPTH = 2 ** IW;

  logic [DATA_W-1:0] acc [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) acc[n] <= '0;
    end else if (clr) begin
      for (int n = 0; n < DEPTH; n++) acc[n] <= '0;
    end else if (add_en) begin
      acc[add_idx] <= acc[add_idx] + add_val;
    end
  end

  assign rd_data = acc[rd_idx];
endmodule

// File: rtl/backprop_sequencer.sv
// Walks N_OUT x N_IN weights through one shared combinational datapath (READ+EXEC per weight),
// then drains per-input error sums on a valid/ready port; done lands 2*N_IN*N_OUT+N_IN+1 cycles after start.
module backprop_sequencer import backprop_pkg::*; #(
  parameter  int N_IN  = 8,
  parameter  int N_OUT = 4,
  parameter  int WA_W  = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1,
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tm,
  input  logic [DATA_W-1:0] td,
  output logic              busy,
  output logic              done,
  output logic [WA_W-1:0]   w_raddr,
  input  logic [DATA_W-1:0] w_rdata,
  output logic              w_we,
  output logic [WA_W-1:0]   w_waddr,
  output logic [DATA_W-1:0] w_wdata,
  output logic [IW-1:0]     p_addr,
  input  logic [DATA_W-1:0] p_data,
  output logic [JW-1:0]     bp_addr,
  input  logic [BP_W-1:0]   bp_data,
  output logic [DATA_W-1:0] dp_p,
  output logic [DATA_W-1:0] dp_w,
  output logic [BP_W-1:0]   dp_bp,
  output logic [DATA_W-1:0] dp_tm,
  output logic [DATA_W-1:0] dp_td,
  input  logic [DATA_W-1:0] dp_bpc,
  input  logic [DATA_W-1:0] dp_wn,
  output logic              err_valid,
  input  logic              err_ready,
  output logic [IW-1:0]     err_idx,
  output logic [DATA_W-1:0] err_data
);
  bps_state_t        state;
  logic [IW-1:0]     i, k;
  logic [JW-1:0]     j;
  logic [DATA_W-1:0] tm_q, td_q;
  logic [DATA_W-1:0] acc_rd;
  logic [WA_W-1:0]   addr;
  logic              rd_ph, exec, drain;

  assign rd_ph = (state == READ);
  assign exec  = (state == EXEC);
  assign drain = (state == DRAIN);
  assign addr  = WA_W'(widx(int'(j), int'(i), N_IN));

  // Everything below decodes registered state, so a reset clears it instantly.
  assign w_raddr   = rd_ph ? addr : '0;
  assign p_addr    = rd_ph ? i : '0;
  assign bp_addr   = rd_ph ? j : '0;
  assign dp_p      = exec ? p_data : '0;
  assign dp_w      = exec ? w_rdata : '0;
  assign dp_bp     = exec ? bp_data : '0;
  assign dp_tm     = tm_q;
  assign dp_td     = td_q;
  // Write goes to the address read one cycle earlier, so read and write never collide.
  assign w_we      = exec;
  assign w_waddr   = exec ? addr : '0;
  assign w_wdata   = exec ? dp_wn : '0;
  assign err_valid = drain;
  assign err_idx   = drain ? k : '0;
  assign err_data  = drain ? acc_rd : '0;

  bp_err_accum #(.N_IN(N_IN), .IW(IW)) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     ((state == IDLE) && start),
    .add_en  (exec),
    .add_idx (i),
    .add_val (dp_bpc),
    .rd_idx  (k),
    .rd_data (acc_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      tm_q  <= '0;
      td_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tm_q  <= tm;
          td_q  <= td;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          busy  <= 1'b1;
          state <= READ;
        end
        READ: state <= EXEC;
        EXEC: begin
          state <= READ;
          if (i == IW'(N_IN - 1)) begin
            i <= '0;
            if (j == JW'(N_OUT - 1)) begin
              j     <= '0;
              state <= DRAIN;
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DRAIN: if (err_ready) begin
          if (k == IW'(N_IN - 1)) begin
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_backprop_sequencer.sv
// Bench for backprop_sequencer: 2x2 layer driven cycle-by-cycle from a vector table plus
// stall / restart / mid-pass reset sequences, and a 1x2 instance for accumulator wrap.
module tb_backprop_sequencer;
  logic clk, rst_n;
  int checks = 0;
  int errors = 0;

  // 2x2 instance
  logic        start, busy, done, w_we, err_valid, err_ready, load;
  logic [31:0] tm, td, w_rdata, w_wdata, p_data, dp_p, dp_w, dp_tm, dp_td, dp_bpc, dp_wn, err_data;
  logic [1:0]  w_raddr, w_waddr;
  logic [0:0]  p_addr, bp_addr, err_idx;
  logic [63:0] bp_data, dp_bp;
  logic [31:0] wmem [4];

  // 1x2 instance
  logic        start2, busy2, done2, w_we2, err_valid2, err_ready2;
  logic [31:0] tm2, td2, w_rdata2, w_wdata2, p_data2, dp_p2, dp_w2, dp_tm2, dp_td2, dp_bpc2, dp_wn2, err_data2;
  logic [0:0]  w_raddr2, w_waddr2, p_addr2, bp_addr2, err_idx2;
  logic [63:0] bp_data2, dp_bp2;
  logic [31:0] wmem2 [2];

  backprop_sequencer #(.N_IN(2), .N_OUT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tm(tm), .td(td), .busy(busy), .done(done),
    .w_raddr(w_raddr), .w_rdata(w_rdata), .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata),
    .p_addr(p_addr), .p_data(p_data), .bp_addr(bp_addr), .bp_data(bp_data),
    .dp_p(dp_p), .dp_w(dp_w), .dp_bp(dp_bp), .dp_tm(dp_tm), .dp_td(dp_td),
    .dp_bpc(dp_bpc), .dp_wn(dp_wn), .err_valid(err_valid), .err_ready(err_ready),
    .err_idx(err_idx), .err_data(err_data));

  backprop_sequencer #(.N_IN(1), .N_OUT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .tm(tm2), .td(td2), .busy(busy2), .done(done2),
    .w_raddr(w_raddr2), .w_rdata(w_rdata2), .w_we(w_we2), .w_waddr(w_waddr2), .w_wdata(w_wdata2),
    .p_addr(p_addr2), .p_data(p_data2), .bp_addr(bp_addr2), .bp_data(bp_data2),
    .dp_p(dp_p2), .dp_w(dp_w2), .dp_bp(dp_bp2), .dp_tm(dp_tm2), .dp_td(dp_td2),
    .dp_bpc(dp_bpc2), .dp_wn(dp_wn2), .err_valid(err_valid2), .err_ready(err_ready2),
    .err_idx(err_idx2), .err_data(err_data2));

  // Stub datapath
  assign dp_bpc  = dp_w + dp_bp[31:0];
  assign dp_wn   = dp_w + 32'd1;
  assign dp_bpc2 = dp_w2 + dp_bp2[31:0];
  assign dp_wn2  = dp_w2 + 32'd1;

  // Memories with one-cycle read latency
  always_ff @(posedge clk) begin
    if (load) begin
      wmem[0] <= 32'd10; wmem[1] <= 32'd20; wmem[2] <= 32'd30; wmem[3] <= 32'd40;
      wmem2[0] <= 32'hFFFF_FFFF; wmem2[1] <= 32'hFFFF_FFFF;
    end else begin
      if (w_we)  wmem[w_waddr]   <= w_wdata;
      if (w_we2) wmem2[w_waddr2] <= w_wdata2;
    end
    w_rdata  <= wmem[w_raddr];
    p_data   <= 32'(p_addr) + 32'd100;
    bp_data  <= bp_addr ? 64'd2 : 64'd1;
    w_rdata2 <= wmem2[w_raddr2];
    p_data2  <= 32'(p_addr2) + 32'd200;
    bp_data2 <= 64'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        busy, done, we;
    logic [1:0]  raddr, waddr;
    logic [31:0] wdata;
    logic        ev;
    logic [0:0]  eidx;
    logic [31:0] edata;
  } obs_t;

  typedef struct packed {
    logic start;
    obs_t exp;
  } row_t;

  function automatic row_t row(logic s, logic b, logic d, logic we, logic [1:0] ra, logic [1:0] wa,
                               logic [31:0] wd, logic ev, logic ei, logic [31:0] ed);
    row_t r;
    r.start = s;
    r.exp.busy = b; r.exp.done = d; r.exp.we = we; r.exp.raddr = ra; r.exp.waddr = wa;
    r.exp.wdata = wd; r.exp.ev = ev; r.exp.eidx = ei; r.exp.edata = ed;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // One full pass on the 2x2 instance; optional restart pulse and drain stall.
  task automatic do_pass(input int restart_at, input int stall, output int done_cyc,
                         output logic [31:0] e0, output logic [31:0] e1,
                         output int tm_bad, output int stall_bad);
    int cyc;
    int stall_left;
    e0 = 32'hBAD0_BAD0; e1 = 32'hBAD0_BAD0;
    done_cyc = -1; tm_bad = 0; stall_bad = 0; stall_left = stall;
    err_ready = 1'b1; tm = 32'd3; td = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tm = 32'h1234_5678; td = 32'h9ABC_DEF0;
    cyc = 1;
    while (cyc < 60 && done_cyc < 0) begin
      start = (cyc == restart_at);
      if (dp_tm != 32'd3 || dp_td != 32'd7) tm_bad++;
      if (err_valid && stall_left > 0) begin
        err_ready = 1'b0;
        stall_left--;
        if (err_idx != 1'b0 || err_data != 32'd43 || done) stall_bad++;
      end else begin
        err_ready = 1'b1;
      end
      if (err_valid && err_ready) begin
        if (err_idx == 1'b0) e0 = err_data;
        else e1 = err_data;
      end
      if (done) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; err_ready = 1'b1;
  endtask

  initial begin
    row_t        tbl [12];
    obs_t        o;
    int          dc, tb_, sb;
    logic [31:0] e0, e1, cap2;

    rst_n = 1'b0; load = 1'b1; start = 1'b0; tm = '0; td = '0; err_ready = 1'b1;
    start2 = 1'b0; tm2 = '0; td2 = '0; err_ready2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctl", 128'({busy, done, w_we, err_valid}), 128'(4'b0));
    check("reset_addr", 128'({w_raddr, w_waddr, p_addr, bp_addr, err_idx}), 128'(7'b0));
    check("reset_data", 128'({err_data, w_wdata}), 128'(64'd0));
    check("reset_dp", 128'({dp_p, dp_w, dp_bp}), 128'(0));
    check("reset_tmtd", 128'({dp_tm, dp_td}), 128'(64'd0));
    load = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;

    // Row t: inputs applied, then state observed t+1 cycles after the start cycle.
    tbl[0]  = row(1'b1, 1, 0, 0, 2'd0, 2'd0, 32'd0,  0, 0, 32'd0);
    tbl[1]  = row(1'b0, 1, 0, 1, 2'd0, 2'd0, 32'd11, 0, 0, 32'd0);
    tbl[2]  = row(1'b0, 1, 0, 0, 2'd1, 2'd0, 32'd0,  0, 0, 32'd0);
    tbl[3]  = row(1'b0, 1, 0, 1, 2'd0, 2'd1, 32'd21, 0, 0, 32'd0);
    tbl[4]  = row(1'b0, 1, 0, 0, 2'd2, 2'd0, 32'd0,  0, 0, 32'd0);
    tbl[5]  = row(1'b0, 1, 0, 1, 2'd0, 2'd2, 32'd31, 0, 0, 32'd0);
    tbl[6]  = row(1'b0, 1, 0, 0, 2'd3, 2'd0, 32'd0,  0, 0, 32'd0);
    tbl[7]  = row(1'b0, 1, 0, 1, 2'd0, 2'd3, 32'd41, 0, 0, 32'd0);
    tbl[8]  = row(1'b0, 1, 0, 0, 2'd0, 2'd0, 32'd0,  1, 0, 32'd43);
    tbl[9]  = row(1'b0, 1, 0, 0, 2'd0, 2'd0, 32'd0,  1, 1, 32'd63);
    tbl[10] = row(1'b0, 0, 1, 0, 2'd0, 2'd0, 32'd0,  0, 0, 32'd0);
    tbl[11] = row(1'b0, 0, 0, 0, 2'd0, 2'd0, 32'd0,  0, 0, 32'd0);

    tm = 32'd3; td = 32'd7;
    for (int t = 0; t < 12; t++) begin
      start = tbl[t].start;
      @(posedge clk); #1;
      start = 1'b0;
      o.busy = busy; o.done = done; o.we = w_we; o.raddr = w_raddr; o.waddr = w_waddr;
      o.wdata = w_wdata; o.ev = err_valid; o.eidx = err_idx; o.edata = err_data;
      check($sformatf("row%0d", t), 128'(o), 128'(tbl[t].exp));
    end
    check("tbl_tmtd", 128'({dp_tm, dp_td}), 128'({32'd3, 32'd7}));
    check("ram0", 128'(wmem[0]), 128'(32'd11));
    check("ram1", 128'(wmem[1]), 128'(32'd21));
    check("ram2", 128'(wmem[2]), 128'(32'd31));
    check("ram3", 128'(wmem[3]), 128'(32'd41));

    // Consumer stalls for 3 cycles at drain entry
    do_load();
    do_pass(-1, 3, dc, e0, e1, tb_, sb);
    check("stall_done_cyc", 128'(dc), 128'(14));
    check("stall_e0", 128'(e0), 128'(32'd43));
    check("stall_e1", 128'(e1), 128'(32'd63));
    check("stall_hold", 128'(sb), 128'(0));
    check("stall_tmtd", 128'(tb_), 128'(0));

    // Second start during the first EXEC is ignored
    do_load();
    do_pass(2, 0, dc, e0, e1, tb_, sb);
    check("restart_done_cyc", 128'(dc), 128'(11));
    check("restart_e0", 128'(e0), 128'(32'd43));
    check("restart_e1", 128'(e1), 128'(32'd63));
    check("restart_tmtd", 128'(tb_), 128'(0));
    check("restart_ram", 128'({wmem[0], wmem[1], wmem[2], wmem[3]}),
          128'({32'd11, 32'd21, 32'd31, 32'd41}));

    // Reset in the third EXEC
    do_load();
    tm = 32'd3; td = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("exec3_pre", 128'({w_we, w_waddr}), 128'({1'b1, 2'd2}));
    rst_n = 1'b0;
    #1;
    check("rst_ctl", 128'({busy, done, w_we, err_valid}), 128'(4'b0));
    check("rst_addr", 128'({w_raddr, w_waddr, p_addr, bp_addr}), 128'(6'b0));
    check("rst_data", 128'({w_wdata, dp_w, dp_bp[31:0]}), 128'(0));
    check("rst_tmtd", 128'({dp_tm, dp_td}), 128'(64'd0));
    @(posedge clk); #1;
    check("rst_partial_ram", 128'({wmem[0], wmem[1], wmem[2], wmem[3]}),
          128'({32'd11, 32'd21, 32'd30, 32'd40}));
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load();
    do_pass(-1, 0, dc, e0, e1, tb_, sb);
    check("post_rst_done_cyc", 128'(dc), 128'(11));
    check("post_rst_e0", 128'(e0), 128'(32'd43));
    check("post_rst_e1", 128'(e1), 128'(32'd63));

    // Accumulator and weight wrap on the 1x2 instance
    do_load();
    cap2 = 32'hBAD0_BAD0; dc = -1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int c = 1; c < 40 && dc < 0; c++) begin
      if (err_valid2) cap2 = err_data2;
      if (done2) dc = c;
      @(posedge clk); #1;
    end
    check("wrap_done_cyc", 128'(dc), 128'(6));
    check("wrap_err", 128'(cap2), 128'(32'd0));
    check("wrap_ram", 128'({wmem2[0], wmem2[1]}), 128'(64'd0));
    check("wrap_idle", 128'({busy2, done2, err_valid2}), 128'(3'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
